// File: rtl/control_sequencer_if.sv
// control_sequencer_if: opcode/flag/handshake inputs and datapath strobes of the control unit
interface control_sequencer_if;
  logic [3:0] opcode;
  logic       z;
  logic       c;
  logic       imem_ready;
  logic       step_mode;
  logic       step;
  logic       LoadIR;
  logic       IncPC;
  logic       LoadPC;
  logic       SelPC;
  logic       LoadAcc;
  logic [1:0] SelAcc;
  logic       LoadReg;
  logic [2:0] SelALU;
  logic       flag_z;
  logic       flag_c;
  logic [2:0] cycle_status;
  logic       halted;
  modport slave (
    input  opcode, z, c, imem_ready, step_mode, step,
    output LoadIR, IncPC, LoadPC, SelPC, LoadAcc, SelAcc, LoadReg, SelALU,
           flag_z, flag_c, cycle_status, halted
  );
  modport master (
    output opcode, z, c, imem_ready, step_mode, step,
    input  LoadIR, IncPC, LoadPC, SelPC, LoadAcc, SelAcc, LoadReg, SelALU,
           flag_z, flag_c, cycle_status, halted
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/execute control FSM with Z/C flags, single-step pause and halt
module control_sequencer (
  input logic clk,
  input logic rst,
  control_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    PAUSE   = 3'd3,
    HALT    = 3'd4
  } state_e;
  state_e     state_q, state_d;
  logic       flag_z_q, flag_z_d, flag_c_q, flag_c_d;
  logic       exe, fetch, alu_op, jmp;
  logic [3:0] alu_sel;
  // Strobes are Mealy and gated by rst so nothing leaks out of an interrupted instruction
  always_comb begin
    exe      = !rst && state_q == EXECUTE;
    fetch    = !rst && state_q == FETCH && bus.imem_ready;
    alu_op   = exe && bus.opcode >= 4'h4 && bus.opcode <= 4'hA;
    alu_sel  = bus.opcode - 4'h4;
    jmp      = bus.opcode == 4'hB || bus.opcode == 4'hE ||
               (bus.opcode == 4'hC && flag_z_q) || (bus.opcode == 4'hD && flag_c_q);
    bus.LoadIR       = fetch;
    bus.IncPC        = fetch;
    bus.LoadPC       = exe && jmp;
    bus.SelPC        = exe && bus.opcode == 4'hE;
    bus.LoadAcc      = alu_op || (exe && (bus.opcode == 4'h1 || bus.opcode == 4'h2));
    bus.SelAcc       = (exe && bus.opcode == 4'h1) ? 2'b01 : (exe && bus.opcode == 4'h2) ? 2'b10 : 2'b00;
    bus.LoadReg      = exe && bus.opcode == 4'h3;
    bus.SelALU       = alu_op ? alu_sel[2:0] : 3'd0;
    bus.flag_z       = flag_z_q;
    bus.flag_c       = flag_c_q;
    bus.cycle_status = state_q;
    bus.halted       = state_q == HALT;
    flag_z_d         = alu_op ? bus.z : flag_z_q;
    flag_c_d         = alu_op ? bus.c : flag_c_q;
    state_d = state_q == FETCH   ? (bus.imem_ready ? DECODE : FETCH) :
              state_q == DECODE  ? EXECUTE :
              state_q == EXECUTE ? (bus.opcode == 4'hF ? HALT : bus.step_mode ? PAUSE : FETCH) :
              state_q == PAUSE   ? ((bus.step || !bus.step_mode) ? FETCH : PAUSE) :
              HALT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end
endmodule
